uio_bus_arbiter: RTL and testbench
==================================

# uio_bus_arbiter

Round-robin arbiter sharing the tile's 8-bit bidirectional `uio` pin bank between `NREQ` internal requesters inside the top-level `tt_um_*` user project. It grants exclusive bus ownership for a bounded burst and latches each owner's direction at grant. It drives `uio_out` and `uio_oe` from registers. It inserts a mandatory oe-low turnaround between owners, so internal blocks never contend on the pads.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_HOLD`, 8: maximum beats per grant, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: request per requester, level.
- `last` in NREQ: marks the owner's final beat.
- `dir` in NREQ: 1 = drive the pads (write), 0 = sample the pads (read).
- `wdata` in NREQ*8: write data; requester i uses bits [8i+7:8i].
- `uio_in` in 8: pad input path.
- `grant` out NREQ: one-hot ownership, registered.
- `uio_out` out 8: pad output data, registered.
- `uio_oe` out 8: pad output enable, registered; 8'hFF or 8'h00 only.
- `rdata` out 8: captured pad data, registered.
- `rvalid` out 1: one-cycle pulse; `rdata` is valid.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, TURN, OWN.
- Reset values: `grant`, `uio_out`, `uio_oe`, `rdata`, `rvalid`, `busy` all 0. State is IDLE. Round-robin pointer `ptr` = NREQ-1, so requester 0 wins first. Hold counter = 0.
- IDLE:
  - Every edge loads `uio_oe`←0 and `uio_out`←0.
  - If any `req` is set, select the first set index scanning ptr+1, ptr+2, … modulo NREQ.
  - Latch owner = that index, `ptr` = owner, `dirL` = `dir[owner]`; go to TURN.
- TURN: lasts exactly one cycle. `uio_oe` stays 0 and `grant` = 0. Go to OWN, setting `grant[owner]`=1 and hold = 0.
- OWN, at each edge:
  - If `req[owner]`=0: release. No beat occurs. Go to IDLE and clear `grant`.
  - Otherwise a beat occurs:
    - `dirL`=1: `uio_out`←`wdata[owner]`, `uio_oe`←8'hFF.
    - `dirL`=0: `rdata`←`uio_in`, `rvalid`←1, `uio_oe`←0.
    - hold increments.
    - If `last[owner]`=1 or hold == MAX_HOLD-1, this is the final beat: go to IDLE and clear `grant`.
- `dir` changes during OWN are ignored; only `dirL` is used.
- `rvalid` is 0 on every edge that is not a read beat.
- `last` and `dir` from non-owners are ignored.
- A requester is re-granted back-to-back only when no other `req` is set.
- Hold counter width: clog2(MAX_HOLD+1).

## Timing
- Request sampled at edge E (state IDLE):
  - TURN occupies cycle E..E+1.
  - `grant` is high from E+1.
  - The first beat is at edge E+2. Its write data is on the pads, or its read `rvalid` is high, in the cycle after E+2.
- Final beat at edge F:
  - `grant` is low from F.
  - The final write data stays on the pads for cycle F..F+1.
  - At F+1 `uio_oe`←0, and the next TURN starts if a request is pending.
  - The next owner's `grant` rises at F+2.
  - Minimum grant gap is 2 cycles; minimum oe-low gap between owners is 1 cycle.
- A forced preempt occurs after exactly MAX_HOLD beats.
- Reset asserted mid-OWN clears all outputs immediately, without waiting for `clk`. It releases the pads the same cycle.
- Simultaneous requests are resolved solely by `ptr`; wrap from NREQ-1 to 0 is required.

## Test plan
- Reset: assert `rst` mid-write-burst → `uio_oe`=0, `grant`=0, `busy`=0 before the next edge. After release, `req`=4'b1111 → `grant`=4'b0001 first.
- Single write: `req[0]`=1, `dir[0]`=1, `wdata[0]`=8'hA5, `last[0]` on the 3rd beat → `grant[0]` high 3 cycles starting 1 cycle after the request edge. `uio_oe`=8'hFF and `uio_out`=8'hA5 for 3 cycles, then `uio_oe`=0.
- Single read: `req[1]`=1, `dir[1]`=0, `uio_in`=8'h3C, `last` on beat 2 → two `rvalid` pulses with `rdata`=8'h3C. `uio_oe` stays 8'h00 throughout.
- Preempt/fairness: `req`=4'b1111 held, no `last`, MAX_HOLD=8 → grants 0,1,2,3,0 in order. Each grant is 8 cycles with a 2-cycle gap. `uio_oe` is 0 for at least 1 cycle between owners.
- Drop and dir-flip: owner 2 writing flips `dir[2]` to 0 mid-grant → still drives, `rvalid` stays 0. Owner 2 then drops `req[2]` → no beat that edge, `grant` falls.
- Wrap: after a grant to 3, `req[0]` and `req[2]` are set simultaneously → 0 wins, then 2.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared 8-bit uio pad bank: one requester per burst,
// direction latched at grant, one oe-low turnaround cycle between owners.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              dirl_q, dirl_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [7:0]        uio_out_q, uio_out_d;
  logic [7:0]        uio_oe_q, uio_oe_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [PW-1:0]     cand;
  logic [PW-1:0]     pick;
  logic              found;

  // Scan ptr+1, ptr+2, ... so the previous owner is considered last.
  always_comb begin
    cand  = ptr_q;
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    dirl_d    = dirl_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    uio_out_d = uio_out_q;
    uio_oe_d  = uio_oe_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        uio_oe_d  = 8'h00;
        uio_out_d = 8'h00;
        if (found) begin
          owner_d = pick;
          ptr_d   = pick;
          dirl_d  = dir[pick];
          state_d = TURN;
        end
      end
      TURN: begin
        grant_d = NREQ'(1) << owner_q;
        hold_d  = '0;
        state_d = OWN;
      end
      OWN: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          if (dirl_q) begin
            uio_out_d = wdata[int'(owner_q)*8 +: 8];
            uio_oe_d  = 8'hFF;
          end else begin
            rdata_d  = uio_in;
            rvalid_d = 1'b1;
            uio_oe_d = 8'h00;
          end
          hold_d = hold_q + HW'(1);
          if (last[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NREQ - 1);
      owner_q   <= '0;
      dirl_q    <= 1'b0;
      hold_q    <= '0;
      grant_q   <= '0;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      dirl_q    <= dirl_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign grant   = grant_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a burst-level reference model.
module tb_uio_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req, last, dir;
  logic [NREQ*8-1:0] wdata;
  logic [7:0]        uio_in;
  logic [NREQ-1:0]   grant;
  logic [7:0]        uio_out, uio_oe, rdata;
  logic              rvalid, busy;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .dir(dir), .wdata(wdata),
    .uio_in(uio_in), .grant(grant), .uio_out(uio_out), .uio_oe(uio_oe),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many beats it has had, and what the
  // pads/outputs must show after the coming edge.
  int              m_ptr, m_owner, m_beats;
  bit              m_turn, m_dirl, model_on;
  logic [NREQ-1:0] e_grant;
  logic [7:0]      e_out, e_oe, e_rdata;
  logic            e_rvalid, e_busy;

  task automatic model_reset();
    m_ptr = NREQ - 1; m_owner = -1; m_beats = 0; m_turn = 0; m_dirl = 0;
    e_grant = '0; e_out = 0; e_oe = 0; e_rdata = 0; e_rvalid = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int pick;
    e_rvalid = 1'b0;
    if (m_owner < 0) begin
      e_oe = 8'h00; e_out = 8'h00;
      pick = -1;
      for (int k = 1; k <= NREQ; k++)
        if (pick < 0 && req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      if (pick >= 0) begin
        m_owner = pick; m_ptr = pick; m_dirl = dir[pick]; m_turn = 1;
      end
    end else if (m_turn) begin
      m_turn = 0; m_beats = 0;
      e_grant = '0; e_grant[m_owner] = 1'b1;
    end else if (!req[m_owner]) begin
      m_owner = -1; e_grant = '0;
    end else begin
      if (m_dirl) begin
        e_out = wdata[m_owner*8 +: 8]; e_oe = 8'hFF;
      end else begin
        e_rdata = uio_in; e_rvalid = 1'b1; e_oe = 8'h00;
      end
      m_beats++;
      if (last[m_owner] || m_beats == MAX_HOLD) begin
        m_owner = -1; e_grant = '0;
      end
    end
    e_busy = (m_owner >= 0);
  endtask

  // Drive inputs before calling: the model consumes them, then the DUT edge does.
  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] g);
    oh_idx = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) oh_idx = i;
  endfunction

  // Compare process: every cycle, DUT against model plus pad-safety properties.
  initial begin : compare
    logic [NREQ-1:0] prev_g;
    int run;
    prev_g = '0; run = 0;
    forever begin
      @(negedge clk);
      if (rst || !model_on) begin
        prev_g = '0; run = 0;
      end else begin
        check("grant",  32'(grant),  32'(e_grant));
        check("uio_out", 32'(uio_out), 32'(e_out));
        check("uio_oe", 32'(uio_oe), 32'(e_oe));
        check("rdata",  32'(rdata),  32'(e_rdata));
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        check("busy",   32'(busy),   32'(e_busy));
        check("oe_legal", 32'(uio_oe == 8'hFF || uio_oe == 8'h00), 32'd1);
        if (grant != 0 && prev_g == 0) check("oe_low_at_grant_rise", 32'(uio_oe), 32'd0);
        if (grant != 0) run++;
        if (grant == 0 && prev_g != 0) begin
          check("hold_bound", 32'(run <= MAX_HOLD), 32'd1);
          run = 0;
        end
        prev_g = grant;
      end
    end
  end

  // Grant recorder for the directed scenarios.
  int              rec_order[$];
  int              rec_len[$];
  int              rec_gap[$];
  logic [NREQ-1:0] rec_prev;
  int              rec_run, rec_zero;

  task automatic rec_clear();
    rec_order.delete(); rec_len.delete(); rec_gap.delete();
    rec_prev = grant; rec_run = 0; rec_zero = 0;
  endtask

  task automatic tick_rec();
    tick();
    if (grant != 0) begin
      if (rec_prev == 0) begin
        rec_order.push_back(oh_idx(grant));
        rec_gap.push_back(rec_zero);
        rec_run = 0;
      end
      rec_run++;
    end else begin
      if (rec_prev != 0) begin
        rec_len.push_back(rec_run);
        rec_zero = 0;
      end
      rec_zero++;
    end
    rec_prev = grant;
  endtask

  initial begin : drive
    int n_a, n_b, first_hi;
    model_on = 0;
    rst = 1'b1; req = '0; last = '0; dir = '0; wdata = '0; uio_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant",  32'(grant),   32'd0);
    check("rst_oe",     32'(uio_oe),  32'd0);
    check("rst_out",    32'(uio_out), 32'd0);
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_rvalid", 32'(rvalid),  32'd0);
    check("rst_rdata",  32'(rdata),   32'd0);
    rst = 1'b0;
    model_reset();
    model_on = 1;

    // Single write burst, last on the third beat.
    dir = 4'b0001; wdata[7:0] = 8'hA5;
    rec_clear(); n_a = 0; first_hi = -1;
    for (int i = 0; i < 8; i++) begin
      req[0] = (i <= 4); last[0] = (i == 4);
      tick_rec();
      if (uio_oe == 8'hFF && uio_out == 8'hA5) n_a++;
      if (first_hi < 0 && grant != 0) first_hi = i;
    end
    check("wr_first_grant_cycle", 32'(first_hi), 32'd1);
    check("wr_grant_count", 32'(rec_order.size()), 32'd1);
    if (rec_len.size() == 1) check("wr_grant_len", 32'(rec_len[0]), 32'd3);
    check("wr_drive_cycles", 32'(n_a), 32'd3);
    check("wr_oe_after", 32'(uio_oe), 32'd0);
    last = '0; req = '0;

    // Single read burst, last on beat two.
    dir = 4'b0000; uio_in = 8'h3C;
    n_a = 0; n_b = 0;
    for (int i = 0; i < 7; i++) begin
      req[1] = (i <= 3); last[1] = (i == 3);
      tick();
      if (rvalid && rdata == 8'h3C) n_a++;
      if (uio_oe != 8'h00) n_b++;
    end
    check("rd_pulses", 32'(n_a), 32'd2);
    check("rd_oe_high_cycles", 32'(n_b), 32'd0);
    last = '0; req = '0;

    // Owner 2 writes, flips dir mid-grant (ignored), then drops req.
    wdata[23:16] = 8'h5A; n_a = 0; n_b = 0;
    for (int i = 0; i < 7; i++) begin
      dir[2] = (i < 3); req[2] = (i <= 4);
      tick();
      if (rvalid) n_a++;
      if (uio_oe == 8'hFF) n_b++;
      if (i == 4) check("flip_grant_held", 32'(grant), 32'h4);
      if (i == 5) begin
        check("drop_grant_low", 32'(grant), 32'd0);
        check("drop_out_held", 32'(uio_out), 32'h5A);
      end
    end
    check("flip_rvalid_count", 32'(n_a), 32'd0);
    check("flip_oe_cycles", 32'(n_b), 32'd4);
    check("drop_oe_released", 32'(uio_oe), 32'd0);
    req = '0; dir = '0;

    // Wrap: after 3, simultaneous 0 and 2 -> 0 first, then 2.
    dir = 4'b1111; last = 4'b1111; wdata = 32'h44332211;
    rec_clear();
    for (int i = 0; i < 12; i++) begin
      req = '0; req[3] = (i <= 2); req[0] = (i >= 2); req[2] = (i >= 2);
      tick_rec();
    end
    check("wrap_count_ok", 32'(rec_order.size() >= 3), 32'd1);
    if (rec_order.size() >= 3) begin
      check("wrap_first",  32'(rec_order[0]), 32'd3);
      check("wrap_second", 32'(rec_order[1]), 32'd0);
      check("wrap_third",  32'(rec_order[2]), 32'd2);
    end
    req = '0; last = '0;
    repeat (3) tick();

    // Asynchronous reset in the middle of a write burst.
    dir = 4'b0010; wdata[15:8] = 8'h77; req = 4'b0010;
    repeat (5) tick();
    check("mid_burst_oe", 32'(uio_oe), 32'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_oe",    32'(uio_oe), 32'd0);
    check("async_grant", 32'(grant),  32'd0);
    check("async_busy",  32'(busy),   32'd0);
    check("async_out",   32'(uio_out), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Preempt / fairness with all four requesting and no last.
    req = 4'b1111; dir = 4'b1111; last = '0;
    rec_clear();
    repeat (50) tick_rec();
    check("pre_grant_count", 32'(rec_order.size()), 32'd5);
    check("pre_len_count",   32'(rec_len.size()),   32'd5);
    if (rec_order.size() == 5 && rec_len.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("pre_order", 32'(rec_order[i]), 32'(i % NREQ));
        check("pre_len",   32'(rec_len[i]),   32'(MAX_HOLD));
        if (i > 0) check("pre_gap", 32'(rec_gap[i]), 32'd2);
      end
    end
    req = '0;
    repeat (4) tick();

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        last[i] = ($urandom_range(4) == 0);
        dir[i]  = $urandom_range(1) == 1;
        wdata[i*8 +: 8] = 8'($urandom);
      end
      uio_in = 8'($urandom);
      tick();
    end
    req = '0; last = '0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
